sdf_stage_ctrl: RTL and testbench

SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

---
 rtl/fft_pkg.sv | 23 ++
 rtl/sdf_stage_ctrl_if.sv | 24 ++
 rtl/twiddle_rom.sv | 27 ++
 rtl/sdf_stage_ctrl.sv | 132 +++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample width, Q8 scale and butterfly mode encodings.
package fft_pkg;

  localparam int unsigned FFT_WIDTH = 24;
  localparam int unsigned Q8_ONE    = 256;
  // Q8 twiddles span -256..256, which needs 10 signed bits
  localparam int unsigned W_BITS    = 10;
  localparam real         PI        = 3.14159265358979323846;

  typedef enum logic [1:0] {
    FILL    = 2'b00,
    SUMDIFF = 2'b01,
    TWIDDLE = 2'b10,
    IDLE    = 2'b11
  } bf_state_e;

  // Round half away from zero; used only to build constant tables
  function automatic int q8_round(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// Butterfly bus between the SDF stage controller (master) and the radix-2 butterfly (slave).
interface sdf_stage_ctrl_if #(
  parameter int unsigned WIDTH = fft_pkg::FFT_WIDTH
);

  logic [1:0]              bf_state;
  logic signed [WIDTH-1:0] bf_a_r, bf_a_i;
  logic signed [WIDTH-1:0] bf_b_r, bf_b_i;
  logic signed [WIDTH-1:0] bf_w_r, bf_w_i;
  logic signed [WIDTH-1:0] bf_op_r, bf_op_i;
  logic signed [WIDTH-1:0] bf_dly_r, bf_dly_i;
  logic                    bf_outvalid;

  modport master (
    output bf_state, bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_w_r, bf_w_i,
    input  bf_op_r, bf_op_i, bf_dly_r, bf_dly_i, bf_outvalid
  );

  modport slave (
    input  bf_state, bf_a_r, bf_a_i, bf_b_r, bf_b_i, bf_w_r, bf_w_i,
    output bf_op_r, bf_op_i, bf_dly_r, bf_dly_i, bf_outvalid
  );

endinterface

// File: rtl/twiddle_rom.sv
// Combinational Q8 twiddle table: w = round(256 * exp(-j*pi*k/DEPTH)), k = 0..DEPTH-1.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned KW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [KW-1:0]            k,
  output logic signed [W_BITS-1:0] w_r,
  output logic signed [W_BITS-1:0] w_i
);

  logic signed [W_BITS-1:0] tab_r [DEPTH];
  logic signed [W_BITS-1:0] tab_i [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    localparam real Ang = PI * real'(g) / real'(DEPTH);
    localparam int  Wr  = q8_round(real'(Q8_ONE) * $cos(Ang));
    localparam int  Wi  = q8_round(-real'(Q8_ONE) * $sin(Ang));
    assign tab_r[g] = W_BITS'(Wr);
    assign tab_i[g] = W_BITS'(Wi);
  end

  assign w_r = tab_r[k];
  assign w_i = tab_i[k];

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Single-path delay-feedback FFT stage controller: delay line, frame counter, butterfly sequencing.
// Optional SDF_FLUSH_EN adds a flush input that injects zero samples to drain the delay line.
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = FFT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] din_r,
  input  logic signed [WIDTH-1:0] din_i,
`ifdef SDF_FLUSH_EN
  input  logic                    flush,
`endif
  sdf_stage_ctrl_if.master        bf,
  output logic signed [WIDTH-1:0] dout_r,
  output logic signed [WIDTH-1:0] dout_i,
  output logic                    out_valid,
  output logic                    out_sof
);

  localparam int unsigned KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(2 * DEPTH);
  localparam logic [CW-1:0] CntMax = CW'(2 * DEPTH - 1);
  localparam logic [CW-1:0] CntSof = CW'(DEPTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] ptr_q, ptr_d;
  logic          primed_q, primed_d;

  logic                    v;
  logic signed [WIDTH-1:0] b_r, b_i;
  logic [KW-1:0]           k;
  logic signed [W_BITS-1:0] rom_w_r, rom_w_i;
  bf_state_e               st;
  logic                    emit;

  logic signed [2*WIDTH-1:0] mem [DEPTH];

`ifdef SDF_FLUSH_EN
  // A flush cycle behaves as a valid zero sample; a real sample always wins
  assign v   = in_valid | flush;
  assign b_r = in_valid ? din_r : '0;
  assign b_i = in_valid ? din_i : '0;
`else
  assign v   = in_valid;
  assign b_r = din_r;
  assign b_i = din_i;
`endif

  assign k    = (DEPTH == 1) ? '0 : cnt_q[KW-1:0];
  assign emit = v & bf.bf_outvalid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      ptr_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      primed_q <= primed_d;
    end
  end

  // Next state: counters only move on a valid sample
  always_comb begin
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    primed_d = primed_q;
    if (v) begin
      cnt_d = cnt_q + 1'b1;
      ptr_d = (DEPTH == 1) ? '0 : ptr_q + 1'b1;
      if (cnt_q == CntMax) primed_d = 1'b1;
    end
  end

  // Outputs to the butterfly
  always_comb begin
    st = IDLE;
    if (v) begin
      if (cnt_q[CW-1])   st = SUMDIFF;
      else if (primed_q) st = TWIDDLE;
      else               st = FILL;
    end
    bf.bf_state = st;
    if (st == TWIDDLE) begin
      bf.bf_w_r = WIDTH'(rom_w_r);
      bf.bf_w_i = WIDTH'(rom_w_i);
    end else begin
      bf.bf_w_r = WIDTH'(Q8_ONE);
      bf.bf_w_i = '0;
    end
  end

  assign bf.bf_b_r = b_r;
  assign bf.bf_b_i = b_i;
  assign {bf.bf_a_r, bf.bf_a_i} = mem[ptr_q];

  twiddle_rom #(
    .DEPTH (DEPTH)
  ) u_twiddle_rom (
    .k   (k),
    .w_r (rom_w_r),
    .w_i (rom_w_i)
  );

  // Delay line contents survive reset; only the pointer is cleared
  always_ff @(posedge clk) begin
    if (!rst && v) mem[ptr_q] <= {bf.bf_dly_r, bf.bf_dly_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r    <= '0;
      dout_i    <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      out_valid <= emit;
      out_sof   <= emit && (cnt_q == CntSof);
      if (emit) begin
        dout_r <= bf.bf_op_r;
        dout_i <= bf.bf_op_i;
      end
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench: three stages (DEPTH 2/4/8) share stimulus; each is checked against a frame-level SDF model.
module tb_sdf_stage_ctrl;

`ifdef SDF_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif
  localparam real Pi = 3.141592653589793;

  typedef struct packed {
    logic               ov;
    logic signed [23:0] op_r, op_i, dly_r, dly_i;
  } bf_res_t;

  logic clk, rst, in_valid, flush;
  logic signed [23:0] din_r, din_i;

  logic signed [23:0] dout_r2, dout_i2, dout_r4, dout_i4, dout_r8, dout_i8;
  logic ov2, ov4, ov8, sof2, sof4, sof8;

  sdf_stage_ctrl_if #(.WIDTH(24)) b2 ();
  sdf_stage_ctrl_if #(.WIDTH(24)) b4 ();
  sdf_stage_ctrl_if #(.WIDTH(24)) b8 ();

  sdf_stage_ctrl #(.DEPTH(2), .WIDTH(24)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
`ifdef SDF_FLUSH_EN
    .flush(flush),
`endif
    .bf(b2.master), .dout_r(dout_r2), .dout_i(dout_i2), .out_valid(ov2), .out_sof(sof2)
  );
  sdf_stage_ctrl #(.DEPTH(4), .WIDTH(24)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
`ifdef SDF_FLUSH_EN
    .flush(flush),
`endif
    .bf(b4.master), .dout_r(dout_r4), .dout_i(dout_i4), .out_valid(ov4), .out_sof(sof4)
  );
  sdf_stage_ctrl #(.DEPTH(8), .WIDTH(24)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
`ifdef SDF_FLUSH_EN
    .flush(flush),
`endif
    .bf(b8.master), .dout_r(dout_r8), .dout_i(dout_i8), .out_valid(ov8), .out_sof(sof8)
  );

  // Radix-2 butterfly attached to each stage
  function automatic bf_res_t bfly(logic [1:0] s, logic signed [23:0] ar, ai, br, bi, wr, wi);
    bf_res_t res;
    longint pr, pim;
    res.ov = 1'b0;
    res.op_r = ar;  res.op_i = ai;
    res.dly_r = br; res.dly_i = bi;
    case (s)
      2'b01: begin
        res.ov = 1'b1;
        res.op_r = ar + br;  res.op_i = ai + bi;
        res.dly_r = ar - br; res.dly_i = ai - bi;
      end
      2'b10: begin
        pr  = (longint'(ar) * longint'(wr) - longint'(ai) * longint'(wi)) >>> 8;
        pim = (longint'(ar) * longint'(wi) + longint'(ai) * longint'(wr)) >>> 8;
        res.ov = 1'b1;
        res.op_r = pr[23:0]; res.op_i = pim[23:0];
      end
      default: ;
    endcase
    return res;
  endfunction

  bf_res_t r2, r4, r8;
  always_comb r2 = bfly(b2.bf_state, b2.bf_a_r, b2.bf_a_i, b2.bf_b_r, b2.bf_b_i, b2.bf_w_r, b2.bf_w_i);
  always_comb r4 = bfly(b4.bf_state, b4.bf_a_r, b4.bf_a_i, b4.bf_b_r, b4.bf_b_i, b4.bf_w_r, b4.bf_w_i);
  always_comb r8 = bfly(b8.bf_state, b8.bf_a_r, b8.bf_a_i, b8.bf_b_r, b8.bf_b_i, b8.bf_w_r, b8.bf_w_i);
  assign {b2.bf_outvalid, b2.bf_op_r, b2.bf_op_i, b2.bf_dly_r, b2.bf_dly_i} = r2;
  assign {b4.bf_outvalid, b4.bf_op_r, b4.bf_op_i, b4.bf_dly_r, b4.bf_dly_i} = r4;
  assign {b8.bf_outvalid, b8.bf_op_r, b8.bf_op_i, b8.bf_dly_r, b8.bf_dly_i} = r8;

  // Observation arrays, index j <-> DEPTH = 2 << j
  logic [1:0] st_o [3];
  int wr_o [3], wi_o [3], dr_o [3], di_o [3];
  logic ov_o [3], sof_o [3];
  always_comb begin
    st_o[0] = b2.bf_state; st_o[1] = b4.bf_state; st_o[2] = b8.bf_state;
    wr_o[0] = int'(b2.bf_w_r); wr_o[1] = int'(b4.bf_w_r); wr_o[2] = int'(b8.bf_w_r);
    wi_o[0] = int'(b2.bf_w_i); wi_o[1] = int'(b4.bf_w_i); wi_o[2] = int'(b8.bf_w_i);
    dr_o[0] = int'(dout_r2); dr_o[1] = int'(dout_r4); dr_o[2] = int'(dout_r8);
    di_o[0] = int'(dout_i2); di_o[1] = int'(dout_i4); di_o[2] = int'(dout_i8);
    ov_o[0] = ov2; ov_o[1] = ov4; ov_o[2] = ov8;
    sof_o[0] = sof2; sof_o[1] = sof4; sof_o[2] = sof8;
  end

  int total = 0, passed = 0;
  int hr[$], hi[$];            // valid samples since the last reset
  int last_r [3], last_i [3];  // expected held dout
  logic [1:0] seen_st [3];
  logic seen_ov [3], seen_sof [3];
  int seen_r [3], seen_i [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  function automatic void twiddle(input int k, input int d, output int wr, output int wi);
    real a;
    a  = Pi * real'(k) / real'(d);
    wr = rnd(256.0 * $cos(a));
    wi = rnd(-256.0 * $sin(a));
  endfunction

  // Frame of 2D samples: second half emits x[n]+x[n+D]; next frame's first half emits
  // (x[n]-x[n+D])*W(n), once a full frame has been seen.
  function automatic int exp_state(int d, int n);
    int pos;
    pos = n % (2 * d);
    if (pos >= d) return 1;
    if (n >= 2 * d) return 2;
    return 0;
  endfunction

  function automatic void exp_out(input int d, input int n, output bit ov, output int r,
                                  output int i, output bit sof);
    int pos, wr, wi;
    longint dr, dim;
    pos = n % (2 * d);
    ov = 1'b0; r = 0; i = 0; sof = 1'b0;
    if (pos >= d) begin
      ov = 1'b1;
      r = hr[n-d] + hr[n];
      i = hi[n-d] + hi[n];
      sof = (pos == d);
    end else if (n >= 2 * d) begin
      dr  = longint'(hr[n-2*d] - hr[n-d]);
      dim = longint'(hi[n-2*d] - hi[n-d]);
      twiddle(pos, d, wr, wi);
      ov = 1'b1;
      r = int'((dr * wr - dim * wi) >>> 8);
      i = int'((dr * wi + dim * wr) >>> 8);
    end
  endfunction

  task automatic do_reset(input logic v);
    rst = 1'b1; in_valid = v; flush = 1'b0;
    din_r = 24'($urandom_range(255)); din_i = 24'($urandom_range(255));
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      total++;
      if (ov_o[j] !== 1'b0 || sof_o[j] !== 1'b0 || dr_o[j] !== 0 || di_o[j] !== 0)
        $display("FAIL reset d=%0d got valid=%0b sof=%0b dout=%0d,%0d want 0,0,0,0",
                 2 << j, ov_o[j], sof_o[j], dr_o[j], di_o[j]);
      else passed++;
      last_r[j] = 0; last_i[j] = 0;
    end
    hr.delete(); hi.delete();
    rst = 1'b0;
  endtask

  // Drive one cycle and compare all three stages against the model
  task automatic apply(input logic v, input logic fl, input int r, input int i);
    bit eff, ov, sof;
    int n, es, wr, wi, er, ei, d;
    in_valid = v; flush = fl; din_r = 24'(r); din_i = 24'(i);
    eff = v || (FlushEn && fl);
    if (eff) begin
      hr.push_back(v ? r : 0);
      hi.push_back(v ? i : 0);
    end
    n = hr.size() - 1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      d = 2 << j;
      es = eff ? exp_state(d, n) : 3;
      seen_st[j] = st_o[j];
      total++;
      if (st_o[j] !== 2'(es))
        $display("FAIL bf_state d=%0d n=%0d got %0d want %0d", d, n, st_o[j], es);
      else passed++;
      wr = 256; wi = 0;
      if (es == 2) twiddle(n % d, d, wr, wi);
      total++;
      if (wr_o[j] !== wr || wi_o[j] !== wi)
        $display("FAIL bf_w d=%0d n=%0d got %0d,%0d want %0d,%0d", d, n, wr_o[j], wi_o[j], wr, wi);
      else passed++;
    end
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      d = 2 << j;
      ov = 1'b0; sof = 1'b0; er = 0; ei = 0;
      if (eff) exp_out(d, n, ov, er, ei, sof);
      if (ov) begin last_r[j] = er; last_i[j] = ei; end
      seen_ov[j] = ov_o[j]; seen_sof[j] = sof_o[j]; seen_r[j] = dr_o[j]; seen_i[j] = di_o[j];
      total++;
      if (ov_o[j] !== ov || sof_o[j] !== sof || dr_o[j] !== last_r[j] || di_o[j] !== last_i[j])
        $display("FAIL output d=%0d n=%0d got v=%0b sof=%0b %0d,%0d want v=%0b sof=%0b %0d,%0d",
                 d, n, ov_o[j], sof_o[j], dr_o[j], di_o[j], ov, sof, last_r[j], last_i[j]);
      else passed++;
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    do_reset(1'b1);
  endtask

  task automatic test_depth2_frame();
    int dv [6] = '{1, 2, 3, 4, 0, 0};
    int st [6] = '{0, 0, 1, 1, 2, 2};
    bit ov [6] = '{0, 0, 1, 1, 1, 1};
    int er [6] = '{0, 0, 4, 6, -2, 0};
    int ei [6] = '{0, 0, 0, 0, 0, 2};
    bit sf [6] = '{0, 0, 1, 0, 0, 0};
    do_reset(1'b0);
    for (int s = 0; s < 6; s++) begin
      apply(1'b1, 1'b0, dv[s], 0);
      total++;
      if (seen_st[0] !== 2'(st[s]) || seen_ov[0] !== ov[s] || seen_sof[0] !== sf[s] ||
          (ov[s] && (seen_r[0] != er[s] || seen_i[0] != ei[s])))
        $display("FAIL d2_frame step=%0d got st=%0d v=%0b sof=%0b %0d,%0d want st=%0d v=%0b sof=%0b %0d,%0d",
                 s, seen_st[0], seen_ov[0], seen_sof[0], seen_r[0], seen_i[0],
                 st[s], ov[s], sf[s], er[s], ei[s]);
      else passed++;
    end
  endtask

  task automatic test_gap();
    do_reset(1'b0);
    for (int s = 1; s <= 4; s++) apply(1'b1, 1'b0, s, 0);
    for (int s = 0; s < 5; s++) begin
      apply(1'b0, 1'b0, int'($urandom_range(500)), int'($urandom_range(500)));
      total++;
      if (seen_st[1] !== 2'b11 || seen_ov[1] !== 1'b0)
        $display("FAIL gap got st=%0d v=%0b want 3,0", seen_st[1], seen_ov[1]);
      else passed++;
    end
    for (int s = 5; s <= 8; s++) begin
      apply(1'b1, 1'b0, s, 0);
      total++;
      if (seen_st[1] !== 2'b01 || seen_ov[1] !== 1'b1 || seen_r[1] != 2 * s - 4)
        $display("FAIL gap_sum got st=%0d v=%0b r=%0d want 1,1,%0d",
                 seen_st[1], seen_ov[1], seen_r[1], 2 * s - 4);
      else passed++;
    end
  endtask

  task automatic test_impulse();
    int er;
    do_reset(1'b0);
    for (int s = 0; s < 24; s++) begin
      apply(1'b1, 1'b0, (s == 0) ? 1000 : 0, 0);
      if (s >= 8) begin
        er = (s == 8 || s == 16) ? 1000 : 0;
        total++;
        if (seen_st[2] !== ((s < 16) ? 2'b01 : 2'b10) || seen_r[2] != er || seen_i[2] != 0)
          $display("FAIL impulse step=%0d got st=%0d %0d,%0d want %0d,0",
                   s, seen_st[2], seen_r[2], seen_i[2], er);
        else passed++;
      end
    end
    // Constant first half: every difference is 1000, so the twiddle outputs are 1000*W(k)
    do_reset(1'b0);
    for (int s = 0; s < 24; s++) begin
      apply(1'b1, 1'b0, (s < 8) ? 1000 : 0, 0);
      if (s == 16 || s == 20) begin
        total++;
        if (seen_r[2] != ((s == 16) ? 1000 : 0) || seen_i[2] != ((s == 16) ? 0 : -1000))
          $display("FAIL twiddle_out step=%0d got %0d,%0d", s, seen_r[2], seen_i[2]);
        else passed++;
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    for (int s = 0; s < 5; s++) apply(1'b1, 1'b0, 10 + s, -s);
    do_reset(1'b1);
    for (int s = 0; s < 17; s++) begin
      apply(1'b1, 1'b0, int'($urandom_range(200)) - 100, int'($urandom_range(200)) - 100);
      total++;
      if (seen_st[2] !== ((s < 8) ? 2'b00 : (s < 16) ? 2'b01 : 2'b10))
        $display("FAIL mid_reset step=%0d got st=%0d", s, seen_st[2]);
      else passed++;
    end
  endtask

  task automatic test_flush();
    do_reset(1'b0);
    for (int s = 1; s <= 4; s++) apply(1'b1, 1'b0, s, 0);
    for (int s = 0; s < 2; s++) begin
      if (FlushEn) apply(1'b0, 1'b1, 55, -9);
      else         apply(1'b1, 1'b0, 0, 0);
      total++;
      if (seen_ov[0] !== 1'b1 || seen_r[0] != ((s == 0) ? -2 : 0) || seen_i[0] != ((s == 0) ? 0 : 2))
        $display("FAIL flush step=%0d got v=%0b %0d,%0d", s, seen_ov[0], seen_r[0], seen_i[0]);
      else passed++;
    end
    // Valid and flush together: the real sample 7 must be used
    do_reset(1'b0);
    apply(1'b1, 1'b1, 7, 0);
    apply(1'b1, 1'b0, 0, 0);
    apply(1'b1, 1'b0, 1, 0);
    total++;
    if (seen_ov[0] !== 1'b1 || seen_r[0] != 8)
      $display("FAIL flush_ignored got v=%0b r=%0d want 1,8", seen_ov[0], seen_r[0]);
    else passed++;
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int s = 0; s < 600; s++) begin
      if ($urandom_range(99) == 0) do_reset(1'($urandom_range(1)));
      else apply(1'($urandom_range(3) != 0), 1'($urandom_range(7) == 0),
                 int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; din_r = '0; din_i = '0;
    test_reset();
    test_depth2_frame();
    test_gap();
    test_impulse();
    test_mid_reset();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
